// File: rtl/ct_clint_func_mc_if.sv
// APB slave bundle for the CLINT function block: request fields driven by the bridge,
// response fields returned by the CLINT.
interface ct_clint_func_mc_if;
  logic        psel_clint;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [1:0]  pprot;
  logic [31:0] prdata_clint;
  logic        pready_clint;
  logic        perr_clint;

  modport master (
    output psel_clint, penable, pwrite, paddr, pwdata, pprot,
    input  prdata_clint, pready_clint, perr_clint
  );

  modport slave (
    input  psel_clint, penable, pwrite, paddr, pwdata, pprot,
    output prdata_clint, pready_clint, perr_clint
  );
endinterface

// File: rtl/ct_clint_func_mc.sv
// Multi-hart CLINT: MSIP/SSIP bits and M/S timer compare registers behind an APB slave
// with one wait state, compared against a locally sampled mtime to raise per-hart interrupts.
module ct_clint_func_mc #(
  parameter int NUM_CORES = 4,
  parameter int MTIME_W   = 64
) (
  input  logic                 forever_apbclk,
  input  logic                 cpurst,
  ct_clint_func_mc_if.slave    apb,
  input  logic                 mtime_en,
  input  logic [MTIME_W-1:0]   sysio_clint_mtime,
  output logic [NUM_CORES-1:0] clint_ms_int,
  output logic [NUM_CORES-1:0] clint_ss_int,
  output logic [NUM_CORES-1:0] clint_mt_int,
  output logic [NUM_CORES-1:0] clint_st_int
);

  localparam int HI_W = MTIME_W - 32;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RESP = 1'b1;

  logic [0:0]  state;
  logic        perr_q;
  logic [31:0] prdata_q;

  logic [NUM_CORES-1:0] msip;
  logic [NUM_CORES-1:0] ssip;
  logic [MTIME_W-1:0]   mtimecmp [NUM_CORES];
  logic [MTIME_W-1:0]   stimecmp [NUM_CORES];
  logic [MTIME_W-1:0]   mtime_reg;

  // Address decode
  logic [15:0] off;
  logic [3:0]  region;
  logic [9:0]  sw_idx;
  logic [8:0]  cmp_idx;
  logic        aligned;
  logic        is_msip, is_mcmp, is_ssip, is_scmp;
  logic        acc_err, priv_err, err;
  logic        access, wr_en;
  logic [31:0] rd_data;
  logic        unused_paddr_hi;

  assign off             = apb.paddr[15:0];
  assign unused_paddr_hi = ^apb.paddr[31:16];
  assign region          = off[15:12];
  assign sw_idx          = off[11:2];
  assign cmp_idx         = off[11:3];
  assign aligned         = (off[1:0] == 2'b00);

  assign is_msip = (region == 4'h0) && aligned && (sw_idx  < 10'(NUM_CORES));
  assign is_mcmp = (region == 4'h4) && aligned && (cmp_idx <  9'(NUM_CORES));
  assign is_ssip = (region == 4'hC) && aligned && (sw_idx  < 10'(NUM_CORES));
  assign is_scmp = (region == 4'hD) && aligned && (cmp_idx <  9'(NUM_CORES));

  assign acc_err  = !(is_msip || is_mcmp || is_ssip || is_scmp);
  // Machine regions need pprot 11; supervisor regions accept 01 or 11.
  assign priv_err = (((region == 4'h0) || (region == 4'h4)) && (apb.pprot != 2'b11)) ||
                    (((region == 4'hC) || (region == 4'hD)) && !apb.pprot[0]);
  assign err      = acc_err || priv_err;

  assign access = (state == IDLE) && apb.psel_clint && apb.penable;
  assign wr_en  = access && apb.pwrite && !err;

  // NOTE: always_comb assigns rd_data a default first so no path leaves it unassigned (no latch).
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (is_msip && (sw_idx == 10'(i))) rd_data = {31'b0, msip[i]};
      if (is_ssip && (sw_idx == 10'(i))) rd_data = {31'b0, ssip[i]};
      if (is_mcmp && (cmp_idx == 9'(i)))
        rd_data = off[2] ? 32'(mtimecmp[i][MTIME_W-1:32]) : mtimecmp[i][31:0];
      if (is_scmp && (cmp_idx == 9'(i)))
        rd_data = off[2] ? 32'(stimecmp[i][MTIME_W-1:32]) : stimecmp[i][31:0];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge forever_apbclk or posedge cpurst) begin
    if (cpurst) begin
      state    <= IDLE;
      perr_q   <= 1'b0;
      prdata_q <= '0;
    end else if (state == IDLE) begin
      if (access) begin
        state    <= RESP;
        perr_q   <= err;
        prdata_q <= (!apb.pwrite && !err) ? rd_data : 32'h0;
      end
    end else begin
      state    <= IDLE;
      perr_q   <= 1'b0;
      prdata_q <= '0;
    end
  end

  assign apb.pready_clint = (state == RESP);
  assign apb.perr_clint   = perr_q;
  assign apb.prdata_clint = prdata_q;

  // NOTE: the compare arrays are reset explicitly to all ones; a reset-less array would fire timers at power-up.
  always_ff @(posedge forever_apbclk or posedge cpurst) begin
    if (cpurst) begin
      msip      <= '0;
      ssip      <= '0;
      mtime_reg <= '0;
      for (int i = 0; i < NUM_CORES; i++) begin
        mtimecmp[i] <= '1;
        stimecmp[i] <= '1;
      end
    end else begin
      if (mtime_en) mtime_reg <= sysio_clint_mtime;
      if (wr_en) begin
        for (int i = 0; i < NUM_CORES; i++) begin
          if (is_msip && (sw_idx == 10'(i))) msip[i] <= apb.pwdata[0];
          if (is_ssip && (sw_idx == 10'(i))) ssip[i] <= apb.pwdata[0];
          if (is_mcmp && (cmp_idx == 9'(i))) begin
            if (off[2]) mtimecmp[i][MTIME_W-1:32] <= apb.pwdata[HI_W-1:0];
            else        mtimecmp[i][31:0]         <= apb.pwdata;
          end
          if (is_scmp && (cmp_idx == 9'(i))) begin
            if (off[2]) stimecmp[i][MTIME_W-1:32] <= apb.pwdata[HI_W-1:0];
            else        stimecmp[i][31:0]         <= apb.pwdata;
          end
        end
      end
    end
  end

  // Timer interrupts: plain unsigned compare, so an mtime wrap to 0 deasserts them.
  always_ff @(posedge forever_apbclk or posedge cpurst) begin
    if (cpurst) begin
      clint_mt_int <= '0;
      clint_st_int <= '0;
    end else begin
      for (int i = 0; i < NUM_CORES; i++) begin
        clint_mt_int[i] <= (mtime_reg >= mtimecmp[i]);
        clint_st_int[i] <= (mtime_reg >= stimecmp[i]);
      end
    end
  end

  assign clint_ms_int = msip;
  assign clint_ss_int = ssip;

endmodule

// File: tb/tb_ct_clint_func_mc.sv
// Directed bench for ct_clint_func_mc (NUM_CORES=4, MTIME_W=64): APB vector table plus
// hand sequences for timer latency, idle-bus immunity and reset during a response.
module tb_ct_clint_func_mc;

  localparam int NC = 4;
  localparam int MW = 64;

  logic          forever_apbclk;
  logic          cpurst;
  logic          mtime_en;
  logic [MW-1:0] sysio_clint_mtime;
  logic [NC-1:0] clint_ms_int, clint_ss_int, clint_mt_int, clint_st_int;

  ct_clint_func_mc_if apb_if ();

  ct_clint_func_mc #(.NUM_CORES(NC), .MTIME_W(MW)) dut (
    .forever_apbclk    (forever_apbclk),
    .cpurst            (cpurst),
    .apb               (apb_if.slave),
    .mtime_en          (mtime_en),
    .sysio_clint_mtime (sysio_clint_mtime),
    .clint_ms_int      (clint_ms_int),
    .clint_ss_int      (clint_ss_int),
    .clint_mt_int      (clint_mt_int),
    .clint_st_int      (clint_st_int)
  );

  initial forever_apbclk = 1'b0;
  always #5 forever_apbclk = ~forever_apbclk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else pass_cnt++;
  endtask

  typedef struct {
    logic        wr;
    logic [1:0]  prot;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [28];

  task automatic apb_xfer(input logic wr, input logic [1:0] prot, input logic [15:0] addr,
                          input logic [31:0] wdata, output logic [31:0] rdata, output logic err);
    int cyc;
    @(negedge forever_apbclk);
    apb_if.psel_clint = 1'b1;
    apb_if.penable    = 1'b0;
    apb_if.pwrite     = wr;
    apb_if.paddr      = {16'h0, addr};
    apb_if.pwdata     = wdata;
    apb_if.pprot      = prot;
    @(negedge forever_apbclk);
    apb_if.penable = 1'b1;
    cyc = 0;
    do begin
      @(negedge forever_apbclk);
      cyc++;
    end while (!apb_if.pready_clint && cyc < 8);
    check($sformatf("pready latency @%h", addr), 64'(cyc), 64'd1);
    rdata = apb_if.prdata_clint;
    err   = apb_if.perr_clint;
    apb_if.psel_clint = 1'b0;
    apb_if.penable    = 1'b0;
  endtask

  task automatic sample_mtime(input logic [MW-1:0] val);
    @(negedge forever_apbclk);
    sysio_clint_mtime = val;
    mtime_en          = 1'b1;
    @(negedge forever_apbclk);
    mtime_en = 1'b0;
  endtask

  logic [31:0] rd;
  logic        er;

  initial begin
    // wr, prot, addr, wdata, expected rdata, expected err
    vecs[0]  = '{1'b0, 2'b11, 16'h4000, 32'h0,   32'hFFFF_FFFF, 1'b0};
    vecs[1]  = '{1'b0, 2'b11, 16'h4004, 32'h0,   32'hFFFF_FFFF, 1'b0};
    vecs[2]  = '{1'b0, 2'b11, 16'hD01C, 32'h0,   32'hFFFF_FFFF, 1'b0};
    vecs[3]  = '{1'b0, 2'b01, 16'hD018, 32'h0,   32'hFFFF_FFFF, 1'b0};
    vecs[4]  = '{1'b0, 2'b11, 16'h0000, 32'h0,   32'h0,         1'b0};
    vecs[5]  = '{1'b1, 2'b11, 16'h000C, 32'h1,   32'h0,         1'b0};
    vecs[6]  = '{1'b1, 2'b01, 16'h0008, 32'h1,   32'h0,         1'b1};
    vecs[7]  = '{1'b0, 2'b11, 16'h000C, 32'h0,   32'h1,         1'b0};
    vecs[8]  = '{1'b0, 2'b11, 16'h0008, 32'h0,   32'h0,         1'b0};
    vecs[9]  = '{1'b0, 2'b01, 16'h0008, 32'h0,   32'h0,         1'b1};
    vecs[10] = '{1'b1, 2'b11, 16'h4010, 32'h100, 32'h0,         1'b0};
    vecs[11] = '{1'b1, 2'b11, 16'h4014, 32'h0,   32'h0,         1'b0};
    vecs[12] = '{1'b0, 2'b11, 16'h4010, 32'h0,   32'h100,       1'b0};
    vecs[13] = '{1'b0, 2'b11, 16'h4014, 32'h0,   32'h0,         1'b0};
    vecs[14] = '{1'b0, 2'b11, 16'h4020, 32'h0,   32'h0,         1'b1};
    vecs[15] = '{1'b1, 2'b11, 16'h4020, 32'h0,   32'h0,         1'b1};
    vecs[16] = '{1'b1, 2'b11, 16'h0010, 32'h1,   32'h0,         1'b1};
    vecs[17] = '{1'b1, 2'b00, 16'hC000, 32'h1,   32'h0,         1'b1};
    vecs[18] = '{1'b0, 2'b01, 16'hC000, 32'h0,   32'h0,         1'b0};
    vecs[19] = '{1'b1, 2'b01, 16'hC000, 32'h3,   32'h0,         1'b0};
    vecs[20] = '{1'b0, 2'b01, 16'hC000, 32'h0,   32'h1,         1'b0};
    vecs[21] = '{1'b0, 2'b10, 16'hC004, 32'h0,   32'h0,         1'b1};
    vecs[22] = '{1'b0, 2'b11, 16'h1000, 32'h0,   32'h0,         1'b1};
    vecs[23] = '{1'b0, 2'b11, 16'h4002, 32'h0,   32'h0,         1'b1};
    vecs[24] = '{1'b0, 2'b11, 16'h4018, 32'h0,   32'hFFFF_FFFF, 1'b0};
    vecs[25] = '{1'b1, 2'b01, 16'h4018, 32'h0,   32'h0,         1'b1};
    vecs[26] = '{1'b0, 2'b11, 16'h4018, 32'h0,   32'hFFFF_FFFF, 1'b0};
    vecs[27] = '{1'b0, 2'b00, 16'hD000, 32'h0,   32'h0,         1'b1};

    apb_if.psel_clint = 1'b0;
    apb_if.penable    = 1'b0;
    apb_if.pwrite     = 1'b0;
    apb_if.paddr      = '0;
    apb_if.pwdata     = '0;
    apb_if.pprot      = 2'b11;
    mtime_en          = 1'b0;
    sysio_clint_mtime = '0;
    cpurst            = 1'b1;

    repeat (3) @(negedge forever_apbclk);
    check("rst pready", 64'(apb_if.pready_clint), 64'd0);
    check("rst perr",   64'(apb_if.perr_clint),   64'd0);
    check("rst prdata", 64'(apb_if.prdata_clint), 64'd0);
    check("rst ints", 64'({clint_ms_int, clint_ss_int, clint_mt_int, clint_st_int}), 64'd0);
    cpurst = 1'b0;
    @(negedge forever_apbclk);
    check("post-rst ints", 64'({clint_ms_int, clint_ss_int, clint_mt_int, clint_st_int}), 64'd0);

    for (int i = 0; i < 28; i++) begin
      apb_xfer(vecs[i].wr, vecs[i].prot, vecs[i].addr, vecs[i].wdata, rd, er);
      check($sformatf("v%0d err @%h", i, vecs[i].addr),   64'(er), 64'(vecs[i].exp_err));
      check($sformatf("v%0d rdata @%h", i, vecs[i].addr), 64'(rd), 64'(vecs[i].exp_rdata));
    end

    @(negedge forever_apbclk);
    check("ms_int after writes", 64'(clint_ms_int), 64'h8);
    check("ss_int after writes", 64'(clint_ss_int), 64'h1);
    check("mt_int before mtime", 64'(clint_mt_int), 64'h0);
    check("st_int before mtime", 64'(clint_st_int), 64'h0);

    // Incomplete bus phases must not write MSIP0.
    @(negedge forever_apbclk);
    apb_if.psel_clint = 1'b1; apb_if.penable = 1'b0; apb_if.pwrite = 1'b1;
    apb_if.paddr = 32'h0; apb_if.pwdata = 32'h1; apb_if.pprot = 2'b11;
    repeat (2) begin
      @(negedge forever_apbclk);
      check("no pready psel only", 64'(apb_if.pready_clint), 64'd0);
    end
    apb_if.psel_clint = 1'b0; apb_if.penable = 1'b1;
    repeat (2) begin
      @(negedge forever_apbclk);
      check("no pready penable only", 64'(apb_if.pready_clint), 64'd0);
    end
    apb_if.penable = 1'b0;
    check("ms_int idle bus", 64'(clint_ms_int), 64'h8);

    // Timer compare against MTIMECMP2 = 0x100.
    sample_mtime(64'hFF);
    @(negedge forever_apbclk);
    check("mt_int mtime 0xFF", 64'(clint_mt_int), 64'h0);
    sample_mtime(64'h100);
    check("mt_int latency", 64'(clint_mt_int), 64'h0);
    @(negedge forever_apbclk);
    check("mt_int mtime 0x100", 64'(clint_mt_int), 64'h4);
    sysio_clint_mtime = 64'h0;
    repeat (2) @(negedge forever_apbclk);
    check("mt_int hold w/o en", 64'(clint_mt_int), 64'h4);
    sample_mtime(64'hFFFF_FFFF_FFFF_FFFF);
    @(negedge forever_apbclk);
    check("mt_int mtime max", 64'(clint_mt_int), 64'hF);
    check("st_int mtime max", 64'(clint_st_int), 64'hF);
    sample_mtime(64'h0);
    @(negedge forever_apbclk);
    check("mt_int wrap", 64'(clint_mt_int), 64'h0);
    check("st_int wrap", 64'(clint_st_int), 64'h0);

    // Supervisor compare write then mtime crossing.
    apb_xfer(1'b1, 2'b01, 16'hD000, 32'h5, rd, er);
    check("stcmp lo err", 64'(er), 64'd0);
    apb_xfer(1'b1, 2'b01, 16'hD004, 32'h0, rd, er);
    check("stcmp hi err", 64'(er), 64'd0);
    sample_mtime(64'h5);
    @(negedge forever_apbclk);
    check("st_int mtime 5", 64'(clint_st_int), 64'h1);

    // Reset asserted in the RESP cycle of a write to STIMECMP0 low.
    @(negedge forever_apbclk);
    apb_if.psel_clint = 1'b1; apb_if.penable = 1'b0; apb_if.pwrite = 1'b1;
    apb_if.paddr = 32'hD000; apb_if.pwdata = 32'h1234; apb_if.pprot = 2'b11;
    @(negedge forever_apbclk);
    apb_if.penable = 1'b1;
    @(posedge forever_apbclk);
    #1;
    check("resp before rst", 64'(apb_if.pready_clint), 64'd1);
    cpurst = 1'b1;
    #1;
    check("pready drops on rst", 64'(apb_if.pready_clint), 64'd0);
    check("perr on rst", 64'(apb_if.perr_clint), 64'd0);
    apb_if.psel_clint = 1'b0; apb_if.penable = 1'b0;
    @(negedge forever_apbclk);
    cpurst = 1'b0;
    check("ints after rst", 64'({clint_ms_int, clint_ss_int, clint_mt_int, clint_st_int}), 64'd0);
    apb_xfer(1'b0, 2'b11, 16'hD000, 32'h0, rd, er);
    check("stcmp0 lo after rst", 64'(rd), 64'hFFFF_FFFF);
    check("stcmp0 lo err", 64'(er), 64'd0);
    apb_xfer(1'b0, 2'b11, 16'h000C, 32'h0, rd, er);
    check("msip3 after rst", 64'(rd), 64'h0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/ct_clint_func_mc.md
Name: ct_clint_func_mc

Overview:
- Parametrised multi-hart CLINT function block: APB slave holding per-hart MSIP/SSIP bits and 64-bit M/S timer compare registers.
- Compares each compare register against a locally sampled copy of the system mtime and drives per-hart software/timer interrupt vectors.
- Successor to the fixed two-hart CLINT. Adds:
  - a hart-count parameter;
  - a decoded APB protocol FSM with one wait state;
  - write-error suppression;
  - registered interrupt outputs;
  - deterministic zero read data on error.
- Sits between the APB bridge and the per-core interrupt inputs.

Parameters:
NUM_CORES, 4, number of harts served; legal 1..16.
MTIME_W, 64, width of mtime and of each compare register; legal 33..64.

Ports:
forever_apbclk  input  1  block clock; free-running APB clock.
cpurst  input  1  asynchronous reset, active high.
psel_clint  input  1  APB select.
penable  input  1  APB enable; access phase when high with psel_clint.
pwrite  input  1  1 = write, 0 = read.
paddr  input  32  byte address; only [15:0] decoded.
pwdata  input  32  write data.
pprot  input  2  privilege: 00 user, 01 supervisor, 11 machine, 10 reserved.
prdata_clint  output  32  read data, valid while pready_clint is high.
pready_clint  output  1  transfer complete.
perr_clint  output  1  slave error, valid while pready_clint is high.
mtime_en  input  1  sample strobe for sysio_clint_mtime.
sysio_clint_mtime  input  MTIME_W  system time.
clint_ms_int  output  NUM_CORES  machine software interrupt per hart.
clint_ss_int  output  NUM_CORES  supervisor software interrupt per hart.
clint_mt_int  output  NUM_CORES  machine timer interrupt per hart.
clint_st_int  output  NUM_CORES  supervisor timer interrupt per hart.

Behaviour:
Address map (paddr[15:0], i = hart index < NUM_CORES; compare regs split as low word at +0, high bits at +4):
- MSIP = 0x0000 + 4i.
- MTIMECMP low = 0x4000 + 8i; high = 0x4004 + 8i.
- SSIP = 0xC000 + 4i.
- STIMECMP low = 0xD000 + 8i; high = 0xD004 + 8i.
- Any other offset, including i >= NUM_CORES, is acc_err.
- Compare high word holds bits [MTIME_W-1:32]. Unused high bits read 0 and ignore writes.

Privilege error (priv_err):
- Address in 0x0xxx or 0x4xxx region and pprot != 11.
- Address in 0xCxxx or 0xDxxx region and pprot is 00 or 10.

APB FSM, states IDLE and RESP:
- IDLE -> RESP on psel_clint && penable. Address, data and errors are evaluated on that edge.
- RESP -> IDLE unconditionally after one cycle.
- pready_clint = 1 only in RESP, so every transfer has exactly one wait state.
- perr_clint is registered with pready_clint: err = acc_err || priv_err.
- prdata_clint is registered on the IDLE->RESP edge: selected register value for an error-free read, else 32'h0.
- Outside RESP, prdata_clint = 0 and perr_clint = 0.

Writes:
- Commit on the IDLE->RESP edge only when pwrite && !err.
- Erroring writes leave all state unchanged.
- MSIP/SSIP take pwdata[0]; other bits read 0.
- psel_clint with penable low, or penable without psel_clint, causes no state change.

mtime sampling:
- mtime_reg loads sysio_clint_mtime on every cycle with mtime_en = 1.
- Otherwise mtime_reg holds.

Interrupts (all registered):
- clint_mt_int[i] <= (mtime_reg >= mtimecmp[i]). clint_st_int is the same with stimecmp[i].
- Latency: one cycle after a mtime_reg or compare-register update.
- clint_ms_int / clint_ss_int equal the MSIP/SSIP flops directly, visible the cycle after the write commits.
- Comparison is unsigned. No wrap handling: when mtime wraps to 0 the interrupt deasserts.

Reset (cpurst high, asynchronous):
- FSM to IDLE; pready_clint = 0; perr_clint = 0; prdata_clint = 0.
- MSIP/SSIP = 0; all compare registers = all ones; mtime_reg = 0.
- All interrupt outputs = 0.
- Reset during RESP aborts the response. A write committed on the prior edge remains lost, because reset clears the register.

Test Plan:
- Reset, NUM_CORES=4: all compare regs read 0xFFFFFFFF; MSIP reads 0; all int vectors 0; each read gives pready_clint high exactly 1 cycle after the access phase.
- Machine write 0x1 to 0x000C -> clint_ms_int = 4'b1000 one cycle after pready; supervisor write to 0x0008 -> perr_clint = 1, clint_ms_int unchanged.
- Write 0x4010 = 0x100, 0x4014 = 0; pulse mtime_en with mtime 0xFF -> clint_mt_int[2] = 0; mtime 0x100 -> clint_mt_int[2] = 1 one cycle after the sample.
- Read 0x4020 with NUM_CORES=4 -> perr_clint = 1, prdata_clint = 0; write there -> no register changes.
- User-mode write 0xC000 = 1 -> perr_clint = 1, clint_ss_int[0] stays 0; supervisor write -> clint_ss_int[0] = 1.
- Assert cpurst during RESP of a write to 0xD000 -> pready_clint drops immediately; STIMECMP0 low reads 0xFFFFFFFF afterwards.
